// File: rtl/wave_fetcher_pkg.sv
// Shared definitions for the wave sample fetcher.
//   fetch_state_e   : bus-fetch FSM states
//   DAC_RESET       : mid-scale DAC code held out of reset
//   BYTE_LANE_ORDER : 2-bit lane index per playback slot, slot 0 in bits [1:0]
//   lane_byte()     : picks the byte of a word for a given playback slot
package wave_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [7:0] DAC_RESET       = 8'h80;
  localparam logic [7:0] BYTE_LANE_ORDER = {2'd3, 2'd2, 2'd1, 2'd0};

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] slot);
    logic [1:0] lane;
    lane = BYTE_LANE_ORDER[{slot, 1'b0} +: 2];
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wave_sample_fetcher_if.sv
// Shared-RAM Wishbone bus seen by the wave sample fetcher.
//   cyc_o/stb_o/we_o/sel_o/adr_o/dat_o : master request side
//   ack_i/dat_i                         : RAM response side
// master modport: the fetcher; slave modport: the RAM.
interface wave_sample_fetcher_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [7:0]  adr_o;
  logic [31:0] dat_o;
  logic        ack_i;
  logic [31:0] dat_i;

  modport master (output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
                  input  ack_i, dat_i);
  modport slave  (input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
                  output ack_i, dat_i);
endinterface

// File: rtl/sample_fifo.sv
// Synchronous word FIFO for prefetched waveform words.
//   clk, rst_n      : clock, async active-low reset (pointers/count only)
//   flush           : empties the FIFO on the next edge, overrides write/read
//   wr_en, wr_data  : push (accepted when not full, or when a pop happens too)
//   rd_en, rd_data  : pop; rd_data shows the head word combinationally
//   full, empty     : occupancy flags
// FIFO_DEPTH must be a power of two, at least 2, so pointers wrap naturally.
module sample_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/wave_sample_fetcher.sv
// Wave sample fetcher: prefetches 32-bit waveform words from shared RAM over
// Wishbone into a small FIFO and plays them out one byte per sample tick.
//   wb_clk_i, wb_rst_ni   : clock, async active-low reset
//   run                   : level enable (rising edge restarts the waveform)
//   start_addr, end_addr  : inclusive word address range of the waveform
//   period                : sample tick interval in clocks, minus one
//   rambus_wb (master)    : read-only Wishbone master to shared RAM
//   dac                   : current sample byte
//   underrun              : sticky, a tick found the FIFO empty
//   underrun_count        : only with UNDERRUN_COUNT_EN, saturating count of
//                           empty ticks, cleared together with underrun
// Optional feature macro: UNDERRUN_COUNT_EN.
module wave_sample_fetcher
  import wave_fetcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             run,
  input  logic [7:0]       start_addr,
  input  logic [7:0]       end_addr,
  input  logic [DIV_W-1:0] period,
  wave_sample_fetcher_if.master rambus_wb,
  output logic [7:0]       dac,
  output logic             underrun
`ifdef UNDERRUN_COUNT_EN
  ,
  output logic [15:0]      underrun_count
`endif
);

  fetch_state_e     state;
  fetch_state_e     state_nx;
  logic             bus_act;
  logic             run_q;
  logic             run_rise;
  logic [7:0]       fetch_addr;
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       byte_idx;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      fifo_rd_data;

  function automatic logic [7:0] next_addr(input logic [7:0] cur, input logic [7:0] first,
                                           input logic [7:0] last);
    // An inverted range collapses to a single-word loop at first.
    if (last < first || cur >= last) return first;
    return cur + 8'd1;
  endfunction

`ifdef UNDERRUN_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign run_rise = run && !run_q;
  assign tick     = run && !run_rise && (tick_cnt == '0);

  // Word acked after run dropped is discarded; stopping always empties the FIFO.
  assign fifo_wr    = (state == ST_REQ) && rambus_wb.ack_i && run;
  assign fifo_flush = !run || (state == ST_DRAIN);
  assign fifo_rd    = tick && !fifo_empty && (byte_idx == 2'd3);

  assign rambus_wb.cyc_o = bus_act;
  assign rambus_wb.stb_o = bus_act;
  assign rambus_wb.we_o  = 1'b0;
  assign rambus_wb.sel_o = 4'hF;
  assign rambus_wb.adr_o = fetch_addr;
  assign rambus_wb.dat_o = 32'h0;

  sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (32)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (rambus_wb.dat_i),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= ST_IDLE;
    else            state <= state_nx;
  end

  // Bus strobes come straight from the state so reset drops them at once.
  always_comb begin
    state_nx = state;
    bus_act  = 1'b0;
    case (state)
      ST_IDLE:  if (run && !fifo_full) state_nx = ST_REQ;
      ST_REQ: begin
        bus_act = 1'b1;
        if (rambus_wb.ack_i) state_nx = run ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Fetch address and sample-tick divider
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      run_q      <= 1'b0;
      fetch_addr <= 8'h00;
      tick_cnt   <= '0;
    end else begin
      run_q <= run;
      if (run_rise)     fetch_addr <= start_addr;
      else if (fifo_wr) fetch_addr <= next_addr(fetch_addr, start_addr, end_addr);
      if (run_rise)     tick_cnt <= period;
      else if (run)     tick_cnt <= tick ? period : tick_cnt - 1'b1;
    end
  end

  // Playback: one byte per tick, word retired after its last lane
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      byte_idx <= 2'd0;
      dac      <= DAC_RESET;
      underrun <= 1'b0;
    end else begin
      if (fifo_flush)                byte_idx <= 2'd0;
      else if (tick && !fifo_empty)  byte_idx <= byte_idx + 2'd1;
      if (tick && !fifo_empty)       dac <= lane_byte(fifo_rd_data, byte_idx);
      if (run_rise)                  underrun <= 1'b0;
      else if (tick && fifo_empty)   underrun <= 1'b1;
    end
  end

`ifdef UNDERRUN_COUNT_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)              underrun_count <= 16'h0000;
    else if (run_rise)           underrun_count <= 16'h0000;
    else if (tick && fifo_empty) underrun_count <= sat_inc16(underrun_count);
  end
`endif

endmodule

// File: tb/tb_wave_sample_fetcher.sv
// Self-checking bench for wave_sample_fetcher. A RAM responder with settable
// ack latency serves the bus; a reference model tracks the expected byte
// stream as a queue, the tick schedule from the period, and the address walk.
`timescale 1ns/1ps
module tb_wave_sample_fetcher;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic [7:0]       start_addr;
  logic [7:0]       end_addr;
  logic [DIV_W-1:0] period;
  logic [7:0]       dac;
  logic             underrun;
`ifdef UNDERRUN_COUNT_EN
  logic [15:0]      underrun_count;
`endif

  wave_sample_fetcher_if bus ();

  wave_sample_fetcher #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .run        (run),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .period     (period),
    .rambus_wb  (bus),
    .dac        (dac),
    .underrun   (underrun)
`ifdef UNDERRUN_COUNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ram [256];
  int          lat;
  bit          stray;
  int          wait_cnt;

  // reference model state
  bit          run_prev;
  int          n;
  logic [7:0]  q [$];
  logic [7:0]  dac_exp;
  bit          ur_exp;
  int          ur_cnt_exp;
  logic [7:0]  addr_exp;
  logic [7:0]  acked [$];
  int          lens [$];
  int          stb_len;
  bit          stb_prev;
  bit          ack_prev;
  logic [7:0]  adr_prev;
  int          words_prev;

  function automatic logic [7:0] model_next(input logic [7:0] a);
    if (end_addr < start_addr) return start_addr;
    if (a >= end_addr) return start_addr;
    return a + 8'd1;
  endfunction

  task automatic model_reset();
    q.delete();
    dac_exp = 8'h80; ur_exp = 0; ur_cnt_exp = 0; run_prev = 0; n = 0;
    stb_prev = 0; ack_prev = 0; adr_prev = 8'h00; words_prev = 0;
    wait_cnt = 0; stb_len = 0; addr_exp = 8'h00;
  endtask

  // Model the cycle in progress, advance one clock, check, then respond.
  task automatic step();
    bit          rise;
    bit          tick;
    int          words_now;
    logic [31:0] w;
    rise = run && !run_prev;
    tick = 0;
    words_now = (q.size() + 3) / 4;
    if (bus.stb_o && !stb_prev) begin
      checks++;
      if (words_prev >= FIFO_DEPTH) begin
        failures++;
        $display("FAIL req_when_full words=%0d required<%0d t=%0t", words_prev, FIFO_DEPTH, $time);
      end
    end
    if (rise) begin
      n = 0; ur_exp = 0; ur_cnt_exp = 0; addr_exp = start_addr;
    end else if (run) begin
      n++;
      tick = ((n % (int'(period) + 1)) == 0);
    end
    if (!run) q.delete();
    if (tick) begin
      if (q.size() == 0) begin
        ur_exp = 1;
        if (ur_cnt_exp < 65535) ur_cnt_exp++;
      end else begin
        dac_exp = q.pop_front();
      end
    end
    if (stb_prev && !ack_prev) begin
      checks++;
      if (bus.stb_o !== 1'b1 || bus.cyc_o !== 1'b1 || bus.adr_o !== adr_prev) begin
        failures++;
        $display("FAIL req_hold stb=%b cyc=%b adr=%02h required stb=1 cyc=1 adr=%02h t=%0t",
                 bus.stb_o, bus.cyc_o, bus.adr_o, adr_prev, $time);
      end
    end
    if (stb_prev && ack_prev) begin
      checks++;
      if (bus.stb_o !== 1'b0 || bus.cyc_o !== 1'b0) begin
        failures++;
        $display("FAIL req_drop stb=%b cyc=%b required 0 t=%0t", bus.stb_o, bus.cyc_o, $time);
      end
    end
    if (bus.stb_o && bus.ack_i) begin
      lens.push_back(stb_len + 1);
      stb_len = 0;
      checks++;
      if (bus.we_o !== 1'b0 || bus.sel_o !== 4'hF || bus.dat_o !== 32'h0) begin
        failures++;
        $display("FAIL bus_const we=%b sel=%h dat=%h required we=0 sel=f dat=0", bus.we_o, bus.sel_o, bus.dat_o);
      end
      if (run) begin
        checks++;
        if (bus.adr_o !== addr_exp) begin
          failures++;
          $display("FAIL fetch_addr actual=%02h required=%02h t=%0t", bus.adr_o, addr_exp, $time);
        end
        acked.push_back(bus.adr_o);
        w = ram[addr_exp];
        q.push_back(w[7:0]);   q.push_back(w[15:8]);
        q.push_back(w[23:16]); q.push_back(w[31:24]);
        addr_exp = model_next(addr_exp);
      end
    end else if (bus.stb_o) begin
      stb_len++;
    end
    words_prev = words_now;
    stb_prev   = bus.stb_o;
    ack_prev   = bus.ack_i;
    adr_prev   = bus.adr_o;
    run_prev   = run;

    @(posedge clk); #1;
    checks++;
    if (dac !== dac_exp) begin
      failures++;
      $display("FAIL dac actual=%02h required=%02h t=%0t", dac, dac_exp, $time);
    end
    checks++;
    if (underrun !== ur_exp) begin
      failures++;
      $display("FAIL underrun actual=%b required=%b t=%0t", underrun, ur_exp, $time);
    end
`ifdef UNDERRUN_COUNT_EN
    checks++;
    if (underrun_count !== 16'(ur_cnt_exp)) begin
      failures++;
      $display("FAIL underrun_count actual=%0d required=%0d t=%0t", underrun_count, ur_cnt_exp, $time);
    end
`endif
    if (bus.stb_o) begin
      if (wait_cnt >= lat) begin
        bus.ack_i = 1'b1; bus.dat_i = ram[bus.adr_o]; wait_cnt = 0;
      end else begin
        bus.ack_i = 1'b0; bus.dat_i = $urandom; wait_cnt++;
      end
    end else begin
      wait_cnt = 0; bus.ack_i = stray; bus.dat_i = $urandom;
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_stb(input int bound);
    int i;
    i = 0;
    while (bus.stb_o !== 1'b1 && i < bound) begin
      step(); i++;
    end
    checks++;
    if (bus.stb_o !== 1'b1) begin
      failures++;
      $display("FAIL wait_stb timeout stb=%b required=1", bus.stb_o);
    end
  endtask

  task automatic fill_ram_random();
    for (int a = 0; a < 256; a++) ram[a] = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0) begin
      failures++; $display("FAIL reset_bus cyc=%b stb=%b required 0", bus.cyc_o, bus.stb_o);
    end
    checks++;
    if (bus.adr_o !== 8'h00) begin
      failures++; $display("FAIL reset_adr actual=%02h required=00", bus.adr_o);
    end
    checks++;
    if (dac !== 8'h80) begin
      failures++; $display("FAIL reset_dac actual=%02h required=80", dac);
    end
    checks++;
    if (underrun !== 1'b0) begin
      failures++; $display("FAIL reset_underrun actual=%b required=0", underrun);
    end
    rst_n = 1'b1;
    model_reset();
    steps(3);
  endtask

  task automatic test_basic();
    logic [7:0] exp_a [4];
    exp_a = '{8'h10, 8'h11, 8'h12, 8'h10};
    fill_ram_random();
    for (int i = 0; i < 3; i++)
      ram[8'h10 + i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    start_addr = 8'h10; end_addr = 8'h12; period = 3; lat = 0; stray = 0;
    acked.delete();
    run = 1'b1;
    steps(80);
    checks++;
    if (acked.size() < 4) begin
      failures++; $display("FAIL basic_reads count=%0d required>=4", acked.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acked[i] !== exp_a[i]) begin
          failures++; $display("FAIL basic_read%0d actual=%02h required=%02h", i, acked[i], exp_a[i]);
        end
      end
    end
    run = 1'b0;
    steps(10);
  endtask

  task automatic test_ack_delay();
    fill_ram_random();
    start_addr = 8'h30; end_addr = 8'h37; period = 20; lat = 5;
    lens.delete();
    run = 1'b1;
    steps(60);
    checks++;
    if (lens.size() < 3) begin
      failures++; $display("FAIL delay_count count=%0d required>=3", lens.size());
    end
    foreach (lens[i]) begin
      checks++;
      if (lens[i] != 6) begin
        failures++; $display("FAIL delay_len%0d actual=%0d required=6", i, lens[i]);
      end
    end
    run = 1'b0;
    steps(10);
  endtask

  task automatic test_underrun();
    fill_ram_random();
    start_addr = 8'h40; end_addr = 8'h4F; period = 0; lat = 3;
    run = 1'b1;
    steps(40);
    checks++;
    if (underrun !== 1'b1) begin
      failures++; $display("FAIL underrun_set actual=%b required=1", underrun);
    end
    run = 1'b0;
    steps(10);
  endtask

  task automatic test_single_loop();
    fill_ram_random();
    start_addr = 8'h20; end_addr = 8'h1F; period = 1; lat = 1;
    acked.delete();
    run = 1'b1;
    steps(50);
    checks++;
    if (acked.size() < 2) begin
      failures++; $display("FAIL loop_count count=%0d required>=2", acked.size());
    end
    foreach (acked[i]) begin
      checks++;
      if (acked[i] !== 8'h20) begin
        failures++; $display("FAIL loop_addr%0d actual=%02h required=20", i, acked[i]);
      end
    end
    run = 1'b0;
    steps(10);
  endtask

  task automatic test_stray_ack();
    fill_ram_random();
    start_addr = 8'h50; end_addr = 8'h53; period = 2; lat = 2; stray = 1;
    run = 1'b1;
    steps(60);
    run = 1'b0;
    steps(10);
    stray = 0;
    steps(2);
  endtask

  task automatic test_run_drop();
    logic [7:0] dac_hold;
    fill_ram_random();
    start_addr = 8'h60; end_addr = 8'h63; period = 5; lat = 2;
    run = 1'b1;
    steps(20);
    wait_stb(20);
    dac_hold = dac;
    run = 1'b0;
    steps(10);
    checks++;
    if (bus.cyc_o !== 1'b0) begin
      failures++; $display("FAIL drop_idle cyc=%b required=0", bus.cyc_o);
    end
    checks++;
    if (dac !== dac_hold) begin
      failures++; $display("FAIL drop_dac actual=%02h required=%02h", dac, dac_hold);
    end
    run = 1'b1;
    steps(40);
    run = 1'b0;
    steps(10);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      fill_ram_random();
      start_addr = 8'($urandom_range(0, 255));
      end_addr   = 8'($urandom_range(0, 255));
      period     = DIV_W'($urandom_range(0, 6));
      lat        = $urandom_range(0, 4);
      run = 1'b1;
      steps($urandom_range(30, 80));
      run = 1'b0;
      steps(10);
    end
  endtask

  task automatic test_reset_mid();
    fill_ram_random();
    start_addr = 8'h70; end_addr = 8'h75; period = 2; lat = 8;
    run = 1'b1;
    steps(15);
    wait_stb(20);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0) begin
      failures++; $display("FAIL mid_reset_bus cyc=%b stb=%b required 0", bus.cyc_o, bus.stb_o);
    end
    checks++;
    if (dac !== 8'h80) begin
      failures++; $display("FAIL mid_reset_dac actual=%02h required=80", dac);
    end
    checks++;
    if (underrun !== 1'b0) begin
      failures++; $display("FAIL mid_reset_underrun actual=%b required=0", underrun);
    end
    run = 1'b0; bus.ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    steps(2);
    lat = 1;
    run = 1'b1;
    steps(30);
    run = 1'b0;
    steps(5);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; start_addr = 8'h00; end_addr = 8'h00; period = '0;
    bus.ack_i = 1'b0; bus.dat_i = 32'h0; lat = 0; stray = 0;
    for (int a = 0; a < 256; a++) ram[a] = 32'h0;
    model_reset();
    test_reset();
    test_basic();
    test_ack_delay();
    test_underrun();
    test_single_loop();
    test_stray_ack();
    test_run_drop();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
